// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice: direction and range-end mode encodings.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-count logic for updown_counter.
// Saturate mode is compiled in only when UPDOWN_COUNTER_SAT_EN is defined;
// otherwise sat_mode is ignored and the counter always wraps.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_cnt,
  output logic             wrap_evt
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic sat;

`ifdef UPDOWN_COUNTER_SAT_EN
  assign sat = (sat_mode == MODE_SAT);
`else
  logic unused_sat_mode;
  assign unused_sat_mode = sat_mode;
  assign sat             = 1'b0;
`endif

  // One step in the selected direction, wrapping or saturating at the range ends.
  always_comb begin
    next_cnt = cnt;
    wrap_evt = 1'b0;
    if (up == DIR_UP) begin
      if (cnt == MAX_CNT) begin
        if (!sat) begin
          next_cnt = '0;
          wrap_evt = 1'b1;
        end
      end else begin
        next_cnt = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        if (!sat) begin
          next_cnt = MAX_CNT;
          wrap_evt = 1'b1;
        end
      end else begin
        next_cnt = cnt - WIDTH'(1);
      end
    end
  end

endmodule : counter_next

// File: rtl/updown_counter.sv
// Modulo up/down counter with parallel load, terminal-count flag and wrap pulse.
// Optional saturate mode is enabled by defining UPDOWN_COUNTER_SAT_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_wrap;

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .cnt      (cnt_q),
    .up       (up),
    .sat_mode (sat_mode),
    .next_cnt (step_cnt),
    .wrap_evt (step_wrap)
  );

  // Load (clamped to the top of the range) beats count enable; otherwise hold.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (load) begin
      cnt_d  = (load_val > MAX_CNT) ? MAX_CNT : load_val;
      wrap_d = 1'b0;
    end else if (en) begin
      cnt_d  = step_cnt;
      wrap_d = step_wrap;
    end
  end

  // Count and wrap registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign tc   = en & ~load & (((up == DIR_UP) & (cnt_q == MAX_CNT)) |
                              ((up == DIR_DOWN) & (cnt_q == '0)));
  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=4, MODULUS=10).
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, sat_mode;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       tc, wrap;

  int total = 0;
  int bad   = 0;

  updown_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .cnt      (cnt),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and move 1 time unit past it before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_cnt;
    int exp_wrap;

    // Reset held for two edges with a load pending.
    rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b0; up = 1'b1; sat_mode = 1'b0;
    step();
    chk("rst1_cnt", cnt, 0);
    chk("rst1_wrap", wrap, 0);
    step();
    chk("rst2_cnt", cnt, 0);
    chk("rst2_wrap", wrap, 0);
    chk("rst_tc_load", tc, 0);

    rst = 1'b0; load = 1'b0;
    step();
    chk("idle1_cnt", cnt, 0);
    step();
    chk("idle2_cnt", cnt, 0);
    chk("idle_tc", tc, 0);

    // Up-count in wrap mode across the top of the range.
    en = 1'b1; up = 1'b1; sat_mode = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      chk($sformatf("up_tc_%0d", i), tc, (exp_cnt == 9) ? 1 : 0);
      step();
      exp_wrap = (exp_cnt == 9) ? 1 : 0;
      exp_cnt  = (exp_cnt == 9) ? 0 : exp_cnt + 1;
      chk($sformatf("up_cnt_%0d", i), cnt, exp_cnt);
      chk($sformatf("up_wrap_%0d", i), wrap, exp_wrap);
    end

    // Down-count in wrap mode across zero.
    load = 1'b1; load_val = 4'd0; up = 1'b0;
    settle();
    chk("dn_tc_load", tc, 0);
    step();
    chk("dn_load_cnt", cnt, 0);
    chk("dn_load_wrap", wrap, 0);
    load = 1'b0;
    settle();
    chk("dn_tc_zero", tc, 1);
    step();
    chk("dn_cnt_9", cnt, 9);
    chk("dn_wrap_9", wrap, 1);
    chk("dn_tc_9", tc, 0);
    step();
    chk("dn_cnt_8", cnt, 8);
    chk("dn_wrap_8", wrap, 0);
    step();
    chk("dn_cnt_7", cnt, 7);

    // Idle holds both cnt and wrap, including a wrap pulse still asserted.
    en = 1'b0;
    step();
    chk("hold_cnt", cnt, 7);
    chk("hold_wrap0", wrap, 0);
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("hold_pre_cnt", cnt, 9);
    chk("hold_pre_wrap", wrap, 1);
    en = 1'b0;
    step();
    chk("hold_wrap1_cnt", cnt, 9);
    chk("hold_wrap1", wrap, 1);

    // Load clamps to MODULUS-1 and wins over enable.
    load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd14;
    step();
    chk("clamp14_cnt", cnt, 9);
    chk("clamp14_wrap", wrap, 0);
    load_val = 4'd15;
    step();
    chk("clamp15_cnt", cnt, 9);
    load_val = 4'd3;
    step();
    chk("load3_cnt", cnt, 3);
    load_val = 4'd9;
    step();
    chk("load9_cnt", cnt, 9);

`ifdef UPDOWN_COUNTER_SAT_EN
    // Saturate at the top, then at the bottom.
    load_val = 4'd8;
    step();
    load = 1'b0; sat_mode = 1'b1; up = 1'b1; en = 1'b1;
    step();
    chk("sat_up1_cnt", cnt, 9);
    settle();
    chk("sat_up1_tc", tc, 1);
    step();
    chk("sat_up2_cnt", cnt, 9);
    chk("sat_up2_wrap", wrap, 0);
    chk("sat_up2_tc", tc, 1);
    step();
    chk("sat_up3_cnt", cnt, 9);
    chk("sat_up3_wrap", wrap, 0);
    load = 1'b1; load_val = 4'd1;
    step();
    load = 1'b0; up = 1'b0;
    step();
    chk("sat_dn1_cnt", cnt, 0);
    step();
    chk("sat_dn2_cnt", cnt, 0);
    chk("sat_dn2_wrap", wrap, 0);
    chk("sat_dn2_tc", tc, 1);
`else
    // sat_mode is ignored in this build: the counter still wraps.
    load = 1'b0; sat_mode = 1'b1; up = 1'b1; en = 1'b1;
    settle();
    chk("nosat_tc", tc, 1);
    step();
    chk("nosat_cnt", cnt, 0);
    chk("nosat_wrap", wrap, 1);
    up = 1'b0;
    step();
    chk("nosat_dn_cnt", cnt, 9);
    chk("nosat_dn_wrap", wrap, 1);
`endif
    sat_mode = 1'b0;

    // Reset beats load.
    rst = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
    step();
    chk("rstld_cnt", cnt, 0);
    chk("rstld_wrap", wrap, 0);

    // Mid-run reset while counting up at 5.
    rst = 1'b0; load_val = 4'd4;
    step();
    chk("mid_load_cnt", cnt, 4);
    load = 1'b0;
    step();
    chk("mid_cnt5", cnt, 5);
    rst = 1'b1;
    step();
    chk("mid_rst_cnt", cnt, 0);
    up = 1'b0;
    settle();
    chk("mid_rst_tc", tc, 1);
    up = 1'b1;
    settle();
    rst = 1'b0;
    step();
    chk("mid_resume1", cnt, 1);
    step();
    chk("mid_resume2", cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_updown_counter
